// File: rtl/move_ctrl_unit.sv
// Hardwired fetch/execute sequencer for the Datapath2 move/IO subset.
// Four cycles per instruction: three fetch states, then one execute state decoding IR.
module move_ctrl_unit #(
  parameter logic [4:0] INC_PC_OP = 5'd12,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      IR,
  input  logic             stop,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             HIout,
  output logic             LOout,
  output logic             InPortout,
  output logic             OutportIn,
  output logic [4:0]       ALU_Control,
  output logic             Run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_HALTED
  } state_t;

  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic       armed_q;
  logic       stop_pending_q;
  logic       sequencing;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode     = IR[31:27];
  assign unused_ir  = ^IR[26:0];
  assign sequencing = (state_q == S_T0) || (state_q == S_T1) ||
                      (state_q == S_T2) || (state_q == S_T3);

  // armed_q holds RST for one full cycle after clr releases before T0 begins.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q        <= S_RST;
      armed_q        <= 1'b0;
      stop_pending_q <= 1'b0;
      instr_count    <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (stop && sequencing)
        stop_pending_q <= 1'b1;
      if (state_q == S_T3)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:    state_d = armed_q ? S_T0 : S_RST;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2:     state_d = S_T3;
      S_T3:     state_d = (opcode == OP_HALT || stop_pending_q || stop) ? S_HALTED : S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RST;
    endcase
  end

  always_comb begin
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    MDRout      = 1'b0;
    MARin       = 1'b0;
    Zin         = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Read        = 1'b0;
    Write       = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    Rin         = 1'b0;
    Rout        = 1'b0;
    HIout       = 1'b0;
    LOout       = 1'b0;
    InPortout   = 1'b0;
    OutportIn   = 1'b0;
    ALU_Control = 5'd0;
    illegal     = 1'b0;
    Run         = sequencing;
    unique case (state_q)
      S_T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        Zin         = 1'b1;
        ALU_Control = INC_PC_OP;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        unique case (opcode)
          OP_MFHI: begin Gra = 1'b1; Rin  = 1'b1; HIout     = 1'b1; end
          OP_MFLO: begin Gra = 1'b1; Rin  = 1'b1; LOout     = 1'b1; end
          OP_IN:   begin Gra = 1'b1; Rin  = 1'b1; InPortout = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
          OP_NOP, OP_HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_move_ctrl_unit.sv
// Self-checking bench for move_ctrl_unit: a cycle-count reference model predicts every
// strobe and the retired count; a narrow-counter second instance exercises wraparound.
`timescale 1ns/1ps
module tb_move_ctrl_unit;

  typedef struct packed {
    logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, HIout, LOout, InPortout, OutportIn, Run, illegal;
    logic [4:0] alu;
  } ctl_t;

  localparam int PH_RST = 4, PH_HALT = 5, PH_CLR = 6;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] IR = '0;

  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, HIout, LOout, InPortout, OutportIn, Run, illegal;
  logic [4:0]  ALU_Control;
  logic [15:0] instr_count;

  logic w_PCout, w_Zlowout, w_MDRout, w_MARin, w_Zin, w_PCin, w_MDRin, w_IRin, w_Read, w_Write;
  logic w_Gra, w_Grb, w_Grc, w_Rin, w_Rout, w_HIout, w_LOout, w_InPortout, w_OutportIn;
  logic w_Run, w_illegal;
  logic [4:0] w_ALU_Control;
  logic [3:0] w_instr_count;

  ctl_t act, act_w;

  always #5 clk = ~clk;

  move_ctrl_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .OutportIn(OutportIn),
    .ALU_Control(ALU_Control), .Run(Run), .illegal(illegal), .instr_count(instr_count)
  );

  move_ctrl_unit #(.INC_PC_OP(5'd12), .CNT_W(4)) dut_w (
    .clk(clk), .clr(clr), .IR(IR), .stop(stop),
    .PCout(w_PCout), .Zlowout(w_Zlowout), .MDRout(w_MDRout), .MARin(w_MARin), .Zin(w_Zin),
    .PCin(w_PCin), .MDRin(w_MDRin), .IRin(w_IRin), .Read(w_Read), .Write(w_Write),
    .Gra(w_Gra), .Grb(w_Grb), .Grc(w_Grc), .Rin(w_Rin), .Rout(w_Rout),
    .HIout(w_HIout), .LOout(w_LOout), .InPortout(w_InPortout), .OutportIn(w_OutportIn),
    .ALU_Control(w_ALU_Control), .Run(w_Run), .illegal(w_illegal), .instr_count(w_instr_count)
  );

  assign act = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Read, Write,
                Gra, Grb, Grc, Rin, Rout, HIout, LOout, InPortout, OutportIn, Run, illegal,
                ALU_Control};
  assign act_w = {w_PCout, w_Zlowout, w_MDRout, w_MARin, w_Zin, w_PCin, w_MDRin, w_IRin,
                  w_Read, w_Write, w_Gra, w_Grb, w_Grc, w_Rin, w_Rout, w_HIout, w_LOout,
                  w_InPortout, w_OutportIn, w_Run, w_illegal, w_ALU_Control};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: position in the instruction stream is derived from edges since clr.
  int          cyc     = 0;
  bit          halted  = 1'b0;
  bit          sp      = 1'b0;
  int unsigned m_count = 0;
  int          m_p;

  function automatic int phase();
    if (clr)    return PH_CLR;
    if (halted) return PH_HALT;
    if (cyc < 2) return PH_RST;
    return (cyc - 2) % 4;
  endfunction

  function automatic ctl_t expected(input int p, input logic [31:0] ir);
    ctl_t e = '0;
    case (p)
      0: begin e.PCout = 1; e.MARin = 1; e.Zin = 1; e.alu = 5'd12; e.Run = 1; end
      1: begin e.Zlowout = 1; e.PCin = 1; e.Read = 1; e.MDRin = 1; e.Run = 1; end
      2: begin e.MDRout = 1; e.IRin = 1; e.Run = 1; end
      3: begin
        e.Run = 1;
        case (ir[31:27])
          5'b11000: begin e.Gra = 1; e.Rin = 1;  e.HIout = 1; end
          5'b11001: begin e.Gra = 1; e.Rin = 1;  e.LOout = 1; end
          5'b10110: begin e.Gra = 1; e.Rin = 1;  e.InPortout = 1; end
          5'b10111: begin e.Gra = 1; e.Rout = 1; e.OutportIn = 1; end
          5'b11010, 5'b11011: ;
          default: e.illegal = 1;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      cyc = 0; halted = 0; sp = 0; m_count = 0;
    end else begin
      m_p = phase();
      if (m_p == PH_RST) cyc++;
      else if (m_p <= 3) begin
        if (m_p == 3) begin
          m_count++;
          if (IR[31:27] == 5'b11011 || sp || stop) halted = 1;
          else cyc++;
        end else cyc++;
        if (stop) sp = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("ctl", 64'(act), 64'(expected(phase(), IR)));
    check("count", 64'(instr_count), 64'(m_count[15:0]));
    check("ctl_w", 64'(act_w), 64'(expected(phase(), IR)));
    check("count_w", 64'(w_instr_count), 64'(m_count[3:0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir_t3, input bit st);
    IR   = (phase() == 3) ? ir_t3 : $urandom;
    stop = st;
    tick();
  endtask

  // Runs one instruction from T0; seen captures the outputs mid-T3.
  task automatic run_instr(input logic [31:0] ir, input int stop_ph, output ctl_t seen);
    int guard = 0;
    seen = '0;
    while (phase() != 0 && guard < 8) begin
      drive(ir, 1'b0);
      guard++;
    end
    if (phase() != 0) begin
      check("reach_t0", 64'(phase()), 64'(0));
      return;
    end
    for (int k = 0; k < 3; k++) drive(ir, k == stop_ph);
    IR   = ir;
    stop = (stop_ph == 3);
    #1;
    seen = act;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    clr = 1'b1;
    #1;
    check("async_clr_ctl", 64'(act), 64'(0));
    check("async_clr_cnt", 64'(instr_count), 64'(0));
    @(posedge clk);
    #2;
    clr = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_ir(input bit allow_halt);
    logic [31:0] r = $urandom;
    logic [4:0]  ops [5] = '{5'b11000, 5'b11001, 5'b10110, 5'b10111, 5'b11010};
    int          sel = $urandom_range(0, 9);
    if (sel < 6)      r[31:27] = ops[$urandom_range(0, 4)];
    else if (sel < 9) r[31:27] = 5'($urandom);
    else              r[31:27] = allow_halt ? 5'b11011 : 5'b11010;
    return r;
  endfunction

  initial begin
    ctl_t seen, lit;
    clr = 1'b1;
    tick();
    do_reset();
    check("rst_cycle_run", 64'(Run), 64'(0));
    tick();
    check("t0_strobes", 64'({PCout, MARin, Zin}), 64'(3'b111));
    check("t0_alu", 64'(ALU_Control), 64'(12));

    run_instr(32'hC200_0000, -1, seen);
    lit = '0; lit.Gra = 1; lit.Rin = 1; lit.HIout = 1; lit.Run = 1;
    check("mfhi_t3", 64'(seen), 64'(lit));
    check("mfhi_count", 64'(instr_count), 64'(1));
    check("mfhi_next_t0", 64'(PCout), 64'(1));

    run_instr(32'hB880_0000, -1, seen);
    lit = '0; lit.Gra = 1; lit.Rout = 1; lit.OutportIn = 1; lit.Run = 1;
    check("out_t3", 64'(seen), 64'(lit));
    run_instr(32'h0800_0000, -1, seen);
    lit = '0; lit.illegal = 1; lit.Run = 1;
    check("illegal_t3", 64'(seen), 64'(lit));

    for (int i = 0; i < 30; i++) run_instr(rand_ir(1'b0), -1, seen);
    check("count_33", 64'(instr_count), 64'(33));

    run_instr(32'hD800_0000, -1, seen);
    check("halt_count", 64'(instr_count), 64'(34));
    for (int i = 0; i < 11; i++) begin
      check("halted_idle", 64'(act), 64'(0));
      drive(32'hC200_0000, 1'b0);
    end

    do_reset();
    run_instr(32'hC880_0000, 1, seen);
    lit = '0; lit.Gra = 1; lit.Rin = 1; lit.LOout = 1; lit.Run = 1;
    check("mflo_stop_t3", 64'(seen), 64'(lit));
    check("mflo_stop_halted", 64'(Run), 64'(0));
    check("mflo_stop_count", 64'(instr_count), 64'(1));

    do_reset();
    run_instr(32'hD000_0000, 3, seen);
    check("stop_in_t3_run", 64'(Run), 64'(0));
    check("stop_in_t3_count", 64'(instr_count), 64'(1));

    do_reset();
    for (int i = 0; i < 15; i++) run_instr(32'hD000_0000, -1, seen);
    check("wrap_pre", 64'(w_instr_count), 64'(4'hF));
    run_instr(32'hD000_0000, -1, seen);
    check("wrap_post", 64'(w_instr_count), 64'(0));
    check("wrap_full", 64'(instr_count), 64'(16));
    drive(32'hD000_0000, 1'b0);
    drive(32'hD000_0000, 1'b0);
    check("t2_before_clr", 64'({IRin, MDRout}), 64'(2'b11));
    do_reset();
    check("restart_rst", 64'(Run), 64'(0));

    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int i = 0; i < 25; i++) begin
        if (phase() == PH_HALT) break;
        run_instr(rand_ir(1'b1), ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : -1, seen);
      end
      repeat (3) drive(rand_ir(1'b1), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
